decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_pkg.sv | 33 +++
 rtl/decode_queue.sv | 76 +++++++
 2 files changed

// File: rtl/decode_queue_pkg.sv
// Shared decoded-instruction record layout between decoder, queue and scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_queue_pkg;

    localparam int ID_TO_SB_WD = 137;

    // Field offsets of the decoded record, MSB down to LSB.
    localparam int EXCEPT_SW_BIT  = 136;
    localparam int EXCEPTTYPE_LSB = 104;
    localparam int OP_LSB         = 92;
    localparam int FU_LSB         = 89;
    localparam int REG1_LSB       = 81;
    localparam int REG2_LSB       = 73;
    localparam int REG3_LSB       = 66;
    localparam int IMM_LSB        = 34;
    localparam int SEL_SRC_LSB    = 32;
    localparam int PC_LSB         = 0;

    typedef struct packed {
        logic        except_sw;
        logic [31:0] excepttype;
        logic [11:0] op;
        logic [2:0]  fu;
        logic [7:0]  reg1;
        logic [7:0]  reg2;
        logic [6:0]  reg3;
        logic [31:0] imm;
        logic [1:0]  sel_src;
        logic [31:0] pc;
    } decode_rec_t;

endpackage

// File: rtl/decode_queue.sv
// In-order queue of decoded instructions between decoder and scoreboard.
// Latency: one cycle from push to head; no same-cycle bypass when empty.
// Backpressure: stall = full from registered count; flush empties in one cycle.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ID_TO_SB_WD
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_info,
    output logic                       stall,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_info,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid & ~full & ~flush;
    assign pop   = ~empty & out_ready & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage has no reset; it is only visible through out_info while occupied.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr] <= in_info;
        end
    end

    assign stall     = full;
    assign out_valid = ~empty;
    assign out_info  = empty ? '0 : mem[rd_ptr];
    assign count     = count_q;

endmodule
